vga_frame_arbiter: RTL and testbench
====================================

# vga_frame_arbiter

Frame-boundary scheduler that shares the single VGA pixel pipeline among up to N_SRC image generators for continuous image generation. It sits between the VGA timing generator (VGA_VS, VGA_BLANK_N) and the pixel sources, and does four things:
- grants exactly one source per frame;
- supplies that source with active-area pixel coordinates;
- emits the per-frame PRINT strobe that frame-capture logic uses to start grabbing a 640x480 image;
- switches sources only at vertical sync, so no frame is ever torn.

## Interface
Parameters:
- N_SRC, 4, number of image sources (2..8)
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- HOLD_FRAMES, 1, frames each source is shown in auto mode (1..255)

Ports:
- CLOCK_25  in  1  pixel clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- VGA_VS  in  1  vertical sync from timing generator, active low
- VGA_BLANK_N  in  1  high during visible pixels
- auto_en  in  1  continuous round-robin cycling enable
- step  in  1  manual advance request, single-cycle pulse
- req  in  N_SRC  source i is ready to drive pixels
- grant  out  N_SRC  one-hot owner of current frame; all-zero = none
- sel  out  $clog2(N_SRC)  binary index of owner (pixel mux select)
- pix_x  out  10  column within visible line
- pix_y  out  9  visible line index
- PRINT  out  1  frame-start strobe
- frame_cnt  out  8  frames displayed since reset, wraps 255->0

## Operation
- Frame boundary (FB): a falling edge of VGA_VS, detected against a registered copy of VGA_VS.
- States:
  - IDLE: grant=0, waits for any req; goes to WAIT_FB.
  - WAIT_FB: at FB, picks an owner and goes to ACTIVE.
  - ACTIVE: stays until FB, then re-evaluates the owner.
- Owner pick at FB:
  - No req bit set: go to IDLE, grant=0.
  - Current owner's req low: forced switch to the next requester after the current index.
  - Otherwise advance once if a step is latched, or if auto_en=1 and the hold counter has reached HOLD_FRAMES.
  - Otherwise keep the current owner.
- Round-robin order: search upward from current index+1 with wrap; the current owner is the last candidate. The first grant after IDLE searches from index 0.
- step pulses are latched in a sticky flag. The flag clears at every FB. Multiple steps within one frame count as one advance. Step and auto expiry in the same frame also count as one advance.
- Hold counter:
  - Reset to 1 on any owner change.
  - Incremented at each FB with no change, saturating at HOLD_FRAMES.
  - Ignored when auto_en=0.
- PRINT rises at FB and falls on the next rising edge of VGA_VS, i.e. its negedge occurs in the vertical back porch, before line 0 is visible. PRINT is driven in every frame in ACTIVE, and never in IDLE.
- frame_cnt increments at every FB in ACTIVE, including the FB that leaves ACTIVE.
- Pixel coordinates:
  - pix_x increments each cycle while VGA_BLANK_N=1, saturating at H_ACTIVE-1, and clears on the VGA_BLANK_N falling edge.
  - pix_y increments on each VGA_BLANK_N falling edge, saturating at V_ACTIVE-1, and clears at FB.
- req bits may change at any time. Only their value sampled at FB matters for arbitration.

## Timing
- Reset values: grant=0, sel=0, pix_x=0, pix_y=0, PRINT=0, frame_cnt=0, state IDLE, step flag 0, hold counter 1.
- grant, sel and PRINT update on the first clock after the cycle in which VGA_VS is sampled low (1-cycle latency from the VS edge).
- pix_x is 0 on the first visible pixel clock of a line, and is registered so it aligns with VGA_BLANK_N delayed by one cycle. The source adds one pipeline stage, so its output aligns with blank delayed by two.
- RESET asserted mid-frame forces all outputs to reset values immediately. After release, the block waits for req and then a full FB before any grant, so partial frames are never granted.
- grant and sel never change between FBs.

## Structure
- Shared package vga_pkg holds:
  - H_ACTIVE, V_ACTIVE and the coordinate widths (10 and 9);
  - the state enum {IDLE, WAIT_FB, ACTIVE};
  - the source-index width function.
- Sub-module vga_rr_pick: combinational round-robin search taking (req, current index, start_from_zero) and returning (next index, found).
- Top block: edge detectors, FSM, step flag, hold counter, coordinate counters, frame counter.

## Test plan
- Two-source handoff: reset, req=4'b0011, auto_en=1, HOLD_FRAMES=1. Expect:
  - grant=0001 after the 1st FB, then 0010, 0001 on successive FBs;
  - one PRINT pulse per frame, with negedge before the first visible line.
- Manual step: auto_en=0, req=4'b1111, owner 0. Give 3 step pulses in one frame, then none. Expect:
  - grant=0010 at the next FB;
  - grant=0010 unchanged at the following FB.
- Forced switch: owner 2, drop req[2] mid-frame with req=4'b1001. Expect:
  - grant stays 0100 until FB;
  - grant=1000 after FB.
- Idle: drop all req. Expect:
  - grant=0 and PRINT stays 0 after the next FB;
  - with req=4'b0100 restored, grant=0100 at the following FB.
- Coordinates: one 640x480 frame. Expect:
  - pix_x runs 0..639 per line;
  - pix_y reaches 479;
  - both clear at FB;
  - frame_cnt wraps 255->0 after 256 frames.
- Reset mid-frame: assert RESET at line 200. Expect:
  - all outputs 0 within the same cycle;
  - the first grant only after a full FB following release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, state encoding and sizing helper for the VGA frame arbiter.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;

    typedef enum logic [1:0] {IDLE, WAIT_FB, ACTIVE} arb_state_t;

    function automatic int src_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/vga_rr_pick.sv
// Combinational round-robin search: first requester above cur (with wrap),
// cur itself last; from_zero starts the scan at index 0 instead.
module vga_rr_pick #(
    parameter int N_SRC = 4,
    parameter int SW    = vga_pkg::src_w(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SW-1:0]    cur,
    input  logic             from_zero,
    output logic [SW-1:0]    nxt,
    output logic             found
);
    import vga_pkg::*;

    always_comb begin
        int start;
        int idx;
        nxt   = '0;
        found = 1'b0;
        start = 0;
        idx   = 0;
        if (!from_zero)
            start = (int'(cur) >= N_SRC - 1) ? 0 : int'(cur) + 1;
        for (int k = 0; k < N_SRC; k++) begin
            idx = start + k;
            if (idx >= N_SRC)
                idx = idx - N_SRC;
            if (!found && req[idx]) begin
                found = 1'b1;
                nxt   = SW'(idx);
            end
        end
    end
endmodule

// File: rtl/vga_frame_arbiter.sv
// Grants the VGA pixel pipeline to one source per frame, switching only at the
// falling edge of VGA_VS, and generates pixel coordinates plus the PRINT strobe.
module vga_frame_arbiter #(
    parameter int N_SRC       = 4,
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int HOLD_FRAMES = 1
) (
    input  logic                             CLOCK_25,
    input  logic                             RESET,
    input  logic                             VGA_VS,
    input  logic                             VGA_BLANK_N,
    input  logic                             auto_en,
    input  logic                             step,
    input  logic [N_SRC-1:0]                 req,
    output logic [N_SRC-1:0]                 grant,
    output logic [vga_pkg::src_w(N_SRC)-1:0] sel,
    output logic [vga_pkg::X_W-1:0]          pix_x,
    output logic [vga_pkg::Y_W-1:0]          pix_y,
    output logic                             PRINT,
    output logic [7:0]                       frame_cnt
);
    import vga_pkg::*;

    localparam int SW = src_w(N_SRC);

    arb_state_t        state, state_nxt;
    logic [SW-1:0]     sel_nxt, pick_idx;
    logic [N_SRC-1:0]  grant_nxt;
    logic              pick_ok, pick_zero, advance;
    logic              vs_q, blank_q, fb, vs_rise, blank_fall;
    logic              step_flg;
    logic [7:0]        hold_cnt;

    // vs_q resets low so a reset released inside vsync cannot fake a boundary.
    assign fb         = vs_q & ~VGA_VS;
    assign vs_rise    = ~vs_q & VGA_VS;
    assign blank_fall = blank_q & ~VGA_BLANK_N;

    assign pick_zero = (state != ACTIVE);
    assign advance   = step_flg | (auto_en & (hold_cnt >= 8'(HOLD_FRAMES)));

    vga_rr_pick #(.N_SRC(N_SRC), .SW(SW)) u_pick (
        .req       (req),
        .cur       (sel),
        .from_zero (pick_zero),
        .nxt       (pick_idx),
        .found     (pick_ok)
    );

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        grant_nxt = '0;
        case (state)
            IDLE: begin
                if (|req)
                    state_nxt = WAIT_FB;
            end
            WAIT_FB: begin
                if (fb) begin
                    if (pick_ok) begin
                        state_nxt = ACTIVE;
                        sel_nxt   = pick_idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            ACTIVE: begin
                if (fb) begin
                    if (!pick_ok) begin
                        state_nxt = IDLE;
                        sel_nxt   = '0;
                    end else if (!req[sel] || advance) begin
                        sel_nxt = pick_idx;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == ACTIVE)
            grant_nxt[sel_nxt] = 1'b1;
    end

    always_ff @(posedge CLOCK_25 or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            sel       <= '0;
            grant     <= '0;
            vs_q      <= 1'b0;
            blank_q   <= 1'b0;
            step_flg  <= 1'b0;
            hold_cnt  <= 8'd1;
            PRINT     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vs_q    <= VGA_VS;
            blank_q <= VGA_BLANK_N;
            state   <= state_nxt;
            sel     <= sel_nxt;
            grant   <= grant_nxt;

            if (fb)
                step_flg <= 1'b0;
            else if (step)
                step_flg <= 1'b1;

            if (fb) begin
                if (state != ACTIVE || sel_nxt != sel)
                    hold_cnt <= 8'd1;
                else if (hold_cnt < 8'(HOLD_FRAMES))
                    hold_cnt <= hold_cnt + 8'd1;
            end

            // PRINT spans vsync only, so it always drops before line 0.
            if (fb)
                PRINT <= (state_nxt == ACTIVE);
            else if (vs_rise)
                PRINT <= 1'b0;

            if (fb && state == ACTIVE)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Coordinates trail VGA_BLANK_N by one cycle: 0 on the first visible clock.
    always_ff @(posedge CLOCK_25 or posedge RESET) begin
        if (RESET) begin
            pix_x <= '0;
            pix_y <= '0;
        end else begin
            if (VGA_BLANK_N) begin
                if (!blank_q)
                    pix_x <= '0;
                else if (pix_x != X_W'(H_ACTIVE - 1))
                    pix_x <= pix_x + 1'b1;
            end else if (blank_q) begin
                pix_x <= '0;
            end

            if (fb)
                pix_y <= '0;
            else if (blank_fall && pix_y != Y_W'(V_ACTIVE - 1))
                pix_y <= pix_y + 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_frame_arbiter.sv
// Directed bench: arbitration sequences, coordinate counters, frame counter wrap and mid-frame reset.
module tb_vga_frame_arbiter;
    logic       CLOCK_25;
    logic       RESET;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       auto_en;
    logic       step;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic       PRINT;
    logic [7:0] frame_cnt;

    int passed = 0;
    int total  = 0;

    vga_frame_arbiter #(
        .N_SRC(4), .H_ACTIVE(640), .V_ACTIVE(480), .HOLD_FRAMES(1)
    ) dut (
        .CLOCK_25    (CLOCK_25),
        .RESET       (RESET),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .auto_en     (auto_en),
        .step        (step),
        .req         (req),
        .grant       (grant),
        .sel         (sel),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .PRINT       (PRINT),
        .frame_cnt   (frame_cnt)
    );

    initial CLOCK_25 = 1'b0;
    always #5 CLOCK_25 = ~CLOCK_25;

    task automatic tick();
        @(posedge CLOCK_25);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One vsync pulse; grant/PRINT checked right after the boundary edge,
    // PRINT checked low once the VS rise has been sampled.
    task automatic fb_check(input string tag, input logic [3:0] eg, input logic ep);
        VGA_VS = 1'b0;
        tick();
        chk({tag, "_grant"}, 32'(grant), 32'(eg));
        chk({tag, "_print"}, 32'(PRINT), 32'(ep));
        tick();
        VGA_VS = 1'b1;
        tick();
        chk({tag, "_print_fall"}, 32'(PRINT), 32'd0);
        tick();
    endtask

    task automatic short_line();
        VGA_BLANK_N = 1'b1;
        tick();
        VGA_BLANK_N = 1'b0;
        tick();
    endtask

    initial begin
        RESET = 1'b1; VGA_VS = 1'b1; VGA_BLANK_N = 1'b0;
        auto_en = 1'b0; step = 1'b0; req = 4'b0000;
        tick(); tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_pix_x", 32'(pix_x), 32'd0);
        chk("rst_pix_y", 32'(pix_y), 32'd0);
        chk("rst_print", 32'(PRINT), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        RESET = 1'b0;
        tick();

        // two-source handoff with auto cycling every frame
        req = 4'b0011; auto_en = 1'b1;
        tick(); tick();
        chk("wait_fb_grant", 32'(grant), 32'd0);
        fb_check("rr1", 4'b0001, 1'b1);
        fb_check("rr2", 4'b0010, 1'b1);
        fb_check("rr3", 4'b0001, 1'b1);
        chk("rr_sel", 32'(sel), 32'd0);
        chk("rr_frame_cnt", 32'(frame_cnt), 32'd2);

        // manual step: three pulses in one frame advance only once
        auto_en = 1'b0; req = 4'b1111;
        tick();
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick();
            step = 1'b0; tick();
        end
        fb_check("step1", 4'b0010, 1'b1);
        fb_check("step_hold", 4'b0010, 1'b1);
        chk("step_sel", 32'(sel), 32'd1);

        // forced switch when the owner drops its request
        step = 1'b1; tick(); step = 1'b0; tick();
        fb_check("to_owner2", 4'b0100, 1'b1);
        tick();
        req = 4'b1001;
        tick(); tick(); tick();
        chk("forced_pre_fb", 32'(grant), 32'b0100);
        fb_check("forced", 4'b1000, 1'b1);
        chk("forced_sel", 32'(sel), 32'd3);
        chk("forced_frame_cnt", 32'(frame_cnt), 32'd6);

        // idle: no requesters -> no grant, no PRINT
        req = 4'b0000;
        tick();
        fb_check("idle", 4'b0000, 1'b0);
        chk("idle_frame_cnt", 32'(frame_cnt), 32'd7);
        req = 4'b0100;
        tick(); tick();
        chk("idle_wait_grant", 32'(grant), 32'd0);
        fb_check("idle_regrant", 4'b0100, 1'b1);
        chk("regrant_frame_cnt", 32'(frame_cnt), 32'd7);

        // coordinates: one full-width line, then short lines to reach 479
        VGA_BLANK_N = 1'b1;
        tick();
        chk("pix_x_first", 32'(pix_x), 32'd0);
        repeat (639) tick();
        chk("pix_x_last", 32'(pix_x), 32'd639);
        repeat (60) tick();
        chk("pix_x_sat", 32'(pix_x), 32'd639);
        VGA_BLANK_N = 1'b0;
        tick();
        chk("pix_x_clear", 32'(pix_x), 32'd0);
        chk("pix_y_line1", 32'(pix_y), 32'd1);
        repeat (478) short_line();
        chk("pix_y_last", 32'(pix_y), 32'd479);
        short_line();
        chk("pix_y_sat", 32'(pix_y), 32'd479);
        fb_check("coord_fb", 4'b0100, 1'b1);
        chk("pix_y_fb_clear", 32'(pix_y), 32'd0);
        chk("pix_x_fb_clear", 32'(pix_x), 32'd0);
        chk("coord_frame_cnt", 32'(frame_cnt), 32'd8);

        // frame counter wrap with short frames
        for (int i = 0; i < 247; i++) begin
            VGA_VS = 1'b0; tick();
            VGA_VS = 1'b1; tick();
        end
        chk("frame_cnt_255", 32'(frame_cnt), 32'd255);
        VGA_VS = 1'b0; tick();
        VGA_VS = 1'b1; tick();
        chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
        chk("wrap_grant", 32'(grant), 32'b0100);

        // reset in the middle of line 200, released inside vsync
        repeat (200) short_line();
        chk("pre_rst_pix_y", 32'(pix_y), 32'd200);
        VGA_BLANK_N = 1'b1;
        repeat (5) tick();
        chk("pre_rst_pix_x", 32'(pix_x), 32'd4);
        RESET = 1'b1;
        #1;
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_pix_x", 32'(pix_x), 32'd0);
        chk("midrst_pix_y", 32'(pix_y), 32'd0);
        chk("midrst_print", 32'(PRINT), 32'd0);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        VGA_BLANK_N = 1'b0;
        VGA_VS = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        tick(); tick(); tick();
        chk("rel_in_vs_grant", 32'(grant), 32'd0);
        VGA_VS = 1'b1;
        tick(); tick();
        chk("rel_vs_high_grant", 32'(grant), 32'd0);
        chk("rel_print", 32'(PRINT), 32'd0);
        fb_check("rel_first_fb", 4'b0100, 1'b1);
        chk("rel_sel", 32'(sel), 32'd2);
        chk("rel_frame_cnt", 32'(frame_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
